// File: rtl/msk_unmask_packer.sv
// Share-recombination packer: XOR-folds d-share masked words into plain words
// and packs N of them into one unmasked block behind a valid/ready handshake.
module msk_unmask_packer #(
    parameter int unsigned D = 2,
    parameter int unsigned W = 32,
    parameter int unsigned N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [W*D-1:0]   in_sh,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W*N-1:0]   out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W*N-1:0]   buf_q, buf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     word_s;

    function automatic logic [W-1:0] recombine(input logic [W*D-1:0] sh);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < int'(W); i++) begin
            for (int j = 0; j < int'(D); j++) begin
                w[i] = w[i] ^ sh[i*D + j];
            end
        end
        return w;
    endfunction

    assign word_s = recombine(in_sh);

    // Next-state logic; flush outranks both handshakes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        if (flush) begin
            state_d = FILL;
            cnt_d   = '0;
            buf_d   = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (in_valid) begin
                        buf_d[cnt_q*W +: W] = word_s;
                        if (cnt_q == CW'(N - 1)) begin
                            state_d = FULL;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state_d = FILL;
                        buf_d   = '0;
                    end else begin
                        state_d = FULL;
                    end
                end
                default: begin
                    state_d = FILL;
                    cnt_d   = '0;
                    buf_d   = '0;
                end
            endcase
        end
        in_ready_d  = (state_d == FILL);
        out_valid_d = (state_d == FULL);
    end

    // State, counter, buffer and handshake output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            buf_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Partial blocks stay internal: the data bus is gated by the registered valid.
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? buf_q : '0;

endmodule

// File: tb/tb_msk_unmask_packer.sv
// Randomized scoreboard bench for msk_unmask_packer with a queue-based reference model.
module tb_msk_unmask_packer;

    localparam int D = 2;
    localparam int W = 32;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, flush, in_valid, out_ready;
    logic [W*D-1:0]   in_sh;
    logic             in_ready, out_valid;
    logic [W*N-1:0]   out_data;

    logic [7:0]  s1_sh, s1_od, s3_od;
    logic [23:0] s3_sh;
    logic        s_valid, s_ready, s1_ir, s1_ov, s3_ir, s3_ov;

    msk_unmask_packer #(.D(D), .W(W), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_sh(in_sh), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );
    msk_unmask_packer #(.D(1), .W(8), .N(1)) dut_d1 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_sh(s1_sh), .in_valid(s_valid),
        .in_ready(s1_ir), .out_data(s1_od), .out_valid(s1_ov), .out_ready(s_ready)
    );
    msk_unmask_packer #(.D(3), .W(8), .N(1)) dut_d3 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_sh(s3_sh), .in_valid(s_valid),
        .in_ready(s3_ir), .out_data(s3_od), .out_valid(s3_ov), .out_ready(s_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;
    longint cyc = 0;

    logic [W-1:0]   cur_word;
    logic [W-1:0]   part[$];
    logic [W*N-1:0] sb[$];
    longint         hs_cyc[$];
    bit             m_full = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Split plain word w into d shares per bit: d-1 random bits plus a closing XOR.
    function automatic logic [95:0] mask(input logic [31:0] w, input int d, input int wb);
        logic [95:0] m;
        bit acc, b;
        m = '0;
        for (int i = 0; i < wb; i++) begin
            acc = 1'b0;
            for (int j = 0; j < d - 1; j++) begin
                b = 1'($urandom);
                m[i*d + j] = b;
                acc = acc ^ b;
            end
            m[i*d + d - 1] = w[i] ^ acc;
        end
        return m;
    endfunction

    function automatic logic [W*N-1:0] pack(input logic [W-1:0] q[$], input logic [W-1:0] last);
        logic [W*N-1:0] blk;
        blk = '0;
        for (int k = 0; k < N - 1; k++) blk[k*W +: W] = q[k];
        blk[(N-1)*W +: W] = last;
        return blk;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: a list of collected plain words and a "block waiting" flag.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            part.delete();
            sb.delete();
            m_full <= 1'b0;
        end else if (flush) begin
            part.delete();
            if (m_full) void'(sb.pop_back());
            m_full <= 1'b0;
        end else if (m_full) begin
            if (out_ready) m_full <= 1'b0;
        end else if (in_valid) begin
            if (part.size() == N - 1) begin
                sb.push_back(pack(part, cur_word));
                part.delete();
                m_full <= 1'b1;
            end else begin
                part.push_back(cur_word);
            end
        end
    end

    // Monitor: handshake flags, data hygiene, and block comparison on consumption.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("in_ready", 128'(in_ready), 128'(!m_full));
            check("out_valid", 128'(out_valid), 128'(m_full));
            if (!out_valid) check("hygiene", 128'(out_data), 128'd0);
            if (out_valid && out_ready && !flush) begin
                hs_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    check("unexpected_block", 128'(out_data), 128'hx);
                end else begin
                    check("block", 128'(out_data), 128'(sb.pop_front()));
                end
            end
        end
    end

    task automatic drive_word(input logic [31:0] w);
        logic [95:0] m;
        m = mask(w, D, W);
        cur_word = w;
        in_sh    = m[W*D-1:0];
    endtask

    task automatic send_beat(input logic [31:0] w, input bit gap);
        int t;
        bit acc;
        drive_word(w);
        in_valid = 1'b1;
        t = 0;
        acc = 1'b0;
        while (!acc && t < 50) begin
            acc = in_ready;
            @(posedge clk); #1;
            t++;
        end
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got no in_ready expected accept within 50 cycles");
        end
        if (gap) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic send_rand_block(input bit gap);
        for (int k = 0; k < N; k++) send_beat($urandom, gap);
        in_valid = 1'b0;
    endtask

    logic [31:0]    kw[4];
    logic [W*N-1:0] kblk;

    initial begin
        kw[0] = 32'h00112233; kw[1] = 32'h44556677;
        kw[2] = 32'h8899AABB; kw[3] = 32'hCCDDEEFF;
        kblk  = 128'hCCDDEEFF_8899AABB_44556677_00112233;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_sh = '0; cur_word = '0;
        s1_sh = '0; s3_sh = '0; s_valid = 1'b0; s_ready = 1'b1;
        #12;
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_data", 128'(out_data), 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Known block, latency, then backpressure with in_valid held high.
        for (int k = 0; k < N; k++) send_beat(kw[k], 1'b0);
        in_valid = 1'b0;
        check("lat_out_valid", 128'(out_valid), 128'd1);
        check("lat_out_data", 128'(out_data), 128'(kblk));
        drive_word($urandom);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_in_ready", 128'(in_ready), 128'd0);
            check("bp_out_data", 128'(out_data), 128'(kblk));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("rel_out_valid", 128'(out_valid), 128'd0);
        check("rel_out_data", 128'(out_data), 128'd0);
        check("rel_in_ready", 128'(in_ready), 128'd1);

        // Gapped input rebuilds the same block.
        for (int k = 0; k < N; k++) send_beat(kw[k], 1'b1);
        repeat (2) @(posedge clk); #1;

        // Full-throughput stream: one block every N+1 cycles.
        hs_cyc.delete();
        for (int b = 0; b < 3; b++)
            for (int k = 0; k < N; k++) send_beat($urandom, 1'b0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("tp_blocks", 128'(hs_cyc.size()), 128'd3);
        for (int i = 1; i < hs_cyc.size(); i++)
            check("tp_period", 128'(hs_cyc[i] - hs_cyc[i-1]), 128'(N + 1));

        // Flush after two beats, with a beat offered in the flush cycle.
        send_beat($urandom, 1'b0);
        send_beat($urandom, 1'b0);
        drive_word($urandom);
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        send_rand_block(1'b0);
        repeat (2) @(posedge clk); #1;

        // Flush while a block waits, even with out_ready high.
        out_ready = 1'b0;
        send_rand_block(1'b0);
        out_ready = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_full_valid", 128'(out_valid), 128'd0);
        send_rand_block(1'b1);
        repeat (2) @(posedge clk); #1;

        // Asynchronous reset while FULL.
        out_ready = 1'b0;
        send_rand_block(1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 128'(out_valid), 128'd0);
        check("arst_out_data", 128'(out_data), 128'd0);
        check("arst_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send_rand_block(1'b0);
        repeat (3) @(posedge clk); #1;

        // d=1 and d=3 with single-beat blocks.
        for (int k = 0; k < 4; k++) begin
            logic [31:0] w;
            logic [95:0] m;
            w = $urandom;
            m = mask(w, 3, 8);
            s1_sh = w[7:0];
            s3_sh = m[23:0];
            s_valid = 1'b1;
            @(posedge clk); #1;
            s_valid = 1'b0;
            check("d1_out_valid", 128'(s1_ov), 128'd1);
            check("d1_in_ready", 128'(s1_ir), 128'd0);
            check("d1_out_data", 128'(s1_od), 128'(w[7:0]));
            check("d3_out_valid", 128'(s3_ov), 128'd1);
            check("d3_out_data", 128'(s3_od), 128'(w[7:0]));
            @(posedge clk); #1;
            check("d1_drain", 128'(s1_ov), 128'd0);
            check("d3_drain_data", 128'(s3_od), 128'd0);
            check("d3_drain_ready", 128'(s3_ir), 128'd1);
        end

        check("sb_empty", 128'(sb.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/msk_unmask_packer.md
# msk_unmask_packer

Sequential share-recombination unit at the output end of the masked datapath: the inverse of the masked gadgets, turning sharings back into plain values. It accepts a stream of masked words (W bits, each carried as d shares) over a valid/ready handshake, XOR-recombines the shares of every bit, and packs N consecutive words into one unmasked block. The block is presented on a second valid/ready port. It sits between the masked cipher core's output sharing bus and the unmasked ciphertext interface.

## Interface
- d, 2: masking order, i.e. number of shares per bit (d ≥ 1).
- W, 32: unmasked bits per input beat.
- N, 4: beats per output block (N ≥ 1).
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous and active-low.
- flush  input  1  synchronous abort; clears buffer and counter.
- in_sh  input  W*d  masked word; shares of bit i at in_sh[i*d +: d].
- in_valid  input  1  in_sh valid.
- in_ready  output  1  unit can accept a beat.
- out_data  output  W*N  unmasked block; beat k occupies out_data[k*W +: W].
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts block.

## Operation
- Recombination: plain bit i = XOR of in_sh[i*d + j] over j = 0..d-1.
  - d=1 passes in_sh through unchanged.
  - Recombination is combinational on the input port only; shares are never registered, only the recombined word is.
- State machine with two states, FILL and FULL, plus beat counter cnt of width max(1, clog2(N)).
- FILL:
  - in_ready=1, out_valid=0.
  - A beat is accepted when in_valid && in_ready. The recombined word is written to slot cnt and cnt increments.
  - Accepting the beat with cnt==N-1 moves the state to FULL and sets cnt to 0 (wrap).
- FULL:
  - in_ready=0, out_valid=1, out_data stable.
  - out_ready=1 returns the state to FILL and clears the whole buffer to zero.
- Hygiene rule: out_data reads all-zero whenever out_valid=0. Partial words are held internally but never driven on out_data.
- flush=1 (sampled on clk) has priority over every other event:
  - state goes to FILL, cnt to 0, buffer to zero.
  - A beat offered in the same cycle is dropped, even though in_ready reads 1.
  - A block offered in the same cycle is discarded, even with out_ready=1.
- Reset (rst_n=0, asynchronous, any time, including mid-block or in FULL):
  - state FILL, cnt 0, buffer zero.
  - in_ready=1, out_valid=0, out_data=0, all immediately.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0.
- in_ready and out_valid are decoded from state registers only. No combinational path from in_valid or out_ready to any output.
- Latency: out_valid rises on the clock edge that accepts beat N-1. The block is visible in the cycle after that handshake.
- Throughput: one block per N+1 cycles minimum, when in_valid=1 and out_ready=1 continuously. There is no bypass from FULL into FILL in the same cycle.
- Input handshake rules:
  - in_valid held low: no state change.
  - in_valid high while in_ready=0 (FULL): no acceptance. Upstream must hold in_sh stable.
- Output handshake rules:
  - out_ready held low in FULL: out_data and out_valid hold indefinitely.
  - out_ready while in FILL: ignored.
- N=1: every accepted beat goes directly to FULL.

## Test plan
- Reset, then d=2, N=4: feed beats whose share pairs XOR to 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF, with random share-0 values -> out_valid rises 1 cycle after the 4th accept; out_data = 0xCCDDEEFF_8899AABB_44556677_00112233.
- Backpressure: hold out_ready=0 for 10 cycles in FULL with in_valid=1 -> in_ready=0 throughout, out_data constant. out_ready=1 -> next cycle out_valid=0, out_data=0, in_ready=1.
- Gapped input: toggle in_valid 1/0 across beats -> same block as the first scenario, no beat lost or duplicated. A full-throughput stream yields exactly one block per 5 cycles.
- Flush after 2 beats, with in_valid=1 in the flush cycle -> that beat is dropped, cnt=0. The next 4 beats form a clean block with no residue from the aborted beats.
- Async reset asserted mid-cycle while in FULL -> out_valid=0, out_data=0, in_ready=1 without waiting for a clk edge. After release, normal operation resumes.
- Parameter sweep d∈{1,3}, N=1 -> single-beat blocks. Recombination equals in_sh for d=1, and equals the 3-share XOR for d=3.
